tug_field: RTL

TUG_FIELD -- requirements
Module: tug_field

---
 rtl/tug_pkg.sv | 27 ++
 rtl/press_pulse.sv | 32 +++
 rtl/tug_field.sv | 60 ++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared constants and helpers for the tug-of-war playfield.
// Positions run 0 (leftmost light) to 8 (rightmost light).
package tug_pkg;

    localparam int POS_W  = 4;
    localparam int N_LEDS = 9;

    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [N_LEDS-1:0] leds_t;

    localparam pos_t POS_MIN    = 4'd0;
    localparam pos_t POS_MAX    = 4'd8;
    localparam pos_t POS_CENTER = 4'd4;
    localparam pos_t POS_STEP   = 4'd1;

    // One-hot decode: position 0 lights leds[8], position 8 lights leds[0].
    function automatic leds_t pos_to_leds(input pos_t pos);
        leds_t leds;
        if (pos <= POS_MAX) begin
            leds = leds_t'(9'd1) << (POS_MAX - pos);
        end else begin
            leds = '0;
        end
        return leds;
    endfunction

endpackage

// File: rtl/press_pulse.sv
// Key conditioning: 2-flop synchronizer, previous-sample flop and a
// registered one-cycle strobe on each released-to-pressed transition.
module press_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pulse;

    // Synchronize the raw key and strobe when the synced sample goes 1 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_prev & ~r_sync2;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playfield: two conditioned keys move a single lit position
// between the walls; a latched winner freezes the position.
module tug_field
    import tug_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              key_l_n,
    input  logic              key_r_n,
    input  logic              game_over,
    output logic [N_LEDS-1:0] leds,
    output logic              left_end,
    output logic              right_end,
    output logic              l_pulse,
    output logic              r_pulse
);

    logic w_l_pulse;
    logic w_r_pulse;
    pos_t r_pos;

    press_pulse u_left (
        .clk   (clk),
        .reset (reset),
        .key_n (key_l_n),
        .pulse (w_l_pulse)
    );

    press_pulse u_right (
        .clk   (clk),
        .reset (reset),
        .key_n (key_r_n),
        .pulse (w_r_pulse)
    );

    // Position update: recovery, freeze/tie, then saturating moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos <= POS_CENTER;
        end else if (r_pos > POS_MAX) begin
            r_pos <= POS_CENTER;
        end else if (game_over || (w_l_pulse == w_r_pulse)) begin
            r_pos <= r_pos;
        end else if (w_l_pulse && (r_pos != POS_MIN)) begin
            r_pos <= r_pos - POS_STEP;
        end else if (w_r_pulse && (r_pos != POS_MAX)) begin
            r_pos <= r_pos + POS_STEP;
        end else begin
            // A press into a wall leaves the light where it is.
            r_pos <= r_pos;
        end
    end

    assign leds      = pos_to_leds(r_pos);
    assign left_end  = (r_pos == POS_MIN);
    assign right_end = (r_pos == POS_MAX);
    assign l_pulse   = w_l_pulse;
    assign r_pulse   = w_r_pulse;

endmodule
